// File: rtl/tron_player_if.sv
// Frame-RAM bus between a Tron light-cycle player and the shared cell frame buffer.
interface tron_player_if;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [7:0]  ram_rdata;

    modport master (output ram_addr, output ram_wdata, output ram_wren, input ram_rdata);
    modport slave  (input ram_addr, input ram_wdata, input ram_wren, output ram_rdata);
endinterface

// File: rtl/tron_player.sv
// One Tron light-cycle: steps one cell per tick, checks the frame RAM ahead for a trail,
// then paints its own trail there or latches a crash.
module tron_player #(
    parameter int         H_CELLS     = 80,
    parameter int         V_CELLS     = 60,
    parameter int         BORDER      = 2,
    parameter int         TICK_CYCLES = 2_000_000,
    parameter int         RAM_LAT     = 2,
    parameter int         INIT_X      = 27,
    parameter int         INIT_Y      = 30,
    parameter int         INIT_DIR    = 0,
    parameter logic [7:0] COLOR       = 8'hFF
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          enable,
    input  logic          key_ccw_n,
    input  logic          key_cw_n,
    tron_player_if.master ramBus,
    output logic [6:0]    pos_x,
    output logic [5:0]    pos_y,
    output logic [1:0]    dir,
    output logic          crashed
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int RW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [RW-1:0] READ_LAST = RW'(RAM_LAT - 1);
    localparam logic [6:0] X_MIN  = 7'(BORDER);
    localparam logic [6:0] X_SPAN = 7'(H_CELLS - 2 * BORDER);
    localparam logic [5:0] Y_MIN  = 6'(BORDER);
    localparam logic [5:0] Y_SPAN = 6'(V_CELLS - 2 * BORDER);

    typedef enum logic [2:0] {INIT, IDLE, CHECK, READ, EVAL, WRITE, CRASH} stateType;

    stateType      r_state, w_nextState;
    logic [2:0]    r_ccwSync, r_cwSync;
    logic          r_pendValid;
    logic [1:0]    r_pendDelta;
    logic [TW-1:0] r_tickCnt;
    logic [RW-1:0] r_readCnt;
    logic [6:0]    r_posX, r_nextX, w_stepX;
    logic [5:0]    r_posY, r_nextY, w_stepY;
    logic [1:0]    r_dir, w_newDir, w_turnDelta;
    logic          r_crashed;
    logic          w_ccwReq, w_cwReq, w_turnReq;
    logic          w_tickEn, w_tick, w_outOfBounds, w_wren;
    logic [12:0]   w_posAddr, w_nextAddr, w_addr;

    // Bit 2 holds the previous synchronized level, so a request is a 1->0 step of bit 1.
    assign w_ccwReq    = r_ccwSync[2] & ~r_ccwSync[1];
    assign w_cwReq     = r_cwSync[2] & ~r_cwSync[1];
    assign w_turnReq   = w_ccwReq ^ w_cwReq;
    assign w_turnDelta = w_cwReq ? 2'd1 : 2'd3;

    assign w_tickEn = enable & ~r_crashed & (r_state == IDLE);
    assign w_tick   = w_tickEn && (r_tickCnt == TICK_LAST);
    assign w_newDir = r_pendValid ? r_dir + r_pendDelta : r_dir;

    always_comb begin
        w_stepX = r_posX;
        w_stepY = r_posY;
        case (w_newDir)
            2'd0:    w_stepX = r_posX + 7'd1;
            2'd1:    w_stepY = r_posY + 6'd1;
            2'd2:    w_stepX = r_posX - 7'd1;
            default: w_stepY = r_posY - 6'd1;
        endcase
    end

    // Offsetting by the border folds both bounds into one unsigned compare; a 0-1 wrap lands high.
    assign w_outOfBounds = ((w_stepX - X_MIN) >= X_SPAN) || ((w_stepY - Y_MIN) >= Y_SPAN);

    assign w_posAddr  = 13'(int'(r_posY) * H_CELLS + int'(r_posX));
    assign w_nextAddr = 13'(int'(r_nextY) * H_CELLS + int'(r_nextX));

    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_wren      = 1'b0;
        w_addr      = w_posAddr;
        case (r_state)
            INIT: begin
                w_wren      = 1'b1;
                w_nextState = IDLE;
            end
            IDLE:  if (w_tick) w_nextState = CHECK;
            CHECK: w_nextState = w_outOfBounds ? CRASH : READ;
            READ: begin
                w_addr = w_nextAddr;
                if (r_readCnt == READ_LAST) w_nextState = EVAL;
            end
            EVAL: begin
                w_addr      = w_nextAddr;
                w_nextState = (ramBus.ram_rdata != 8'd0) ? CRASH : WRITE;
            end
            WRITE: begin
                w_addr      = w_nextAddr;
                w_wren      = 1'b1;
                w_nextState = IDLE;
            end
            CRASH:   w_nextState = CRASH;
            default: w_nextState = INIT;
        endcase
        // Holding reset keeps the INIT write from repeating every cycle.
        if (reset) w_wren = 1'b0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_ccwSync   <= 3'b111;
            r_cwSync    <= 3'b111;
            r_pendValid <= 1'b0;
            r_pendDelta <= 2'd0;
            r_tickCnt   <= '0;
            r_readCnt   <= '0;
            r_posX      <= 7'(INIT_X);
            r_posY      <= 6'(INIT_Y);
            r_nextX     <= 7'(INIT_X);
            r_nextY     <= 6'(INIT_Y);
            r_dir       <= 2'(INIT_DIR);
            r_crashed   <= 1'b0;
        end else begin
            r_ccwSync <= {r_ccwSync[1:0], key_ccw_n};
            r_cwSync  <= {r_cwSync[1:0], key_cw_n};

            if (w_tickEn) r_tickCnt <= (r_tickCnt == TICK_LAST) ? '0 : r_tickCnt + 1'b1;

            // CHECK consumes the pending turn; a request arriving that same cycle waits for the next tick.
            if (r_state == CHECK) begin
                r_pendValid <= w_turnReq;
                r_pendDelta <= w_turnDelta;
            end else if (!r_pendValid && w_turnReq) begin
                r_pendValid <= 1'b1;
                r_pendDelta <= w_turnDelta;
            end

            if (r_state == CHECK) begin
                r_dir   <= w_newDir;
                r_nextX <= w_stepX;
                r_nextY <= w_stepY;
            end

            if (r_state == READ) r_readCnt <= r_readCnt + 1'b1;
            else                 r_readCnt <= '0;

            if (r_state == WRITE) begin
                r_posX <= r_nextX;
                r_posY <= r_nextY;
            end

            if (w_nextState == CRASH) r_crashed <= 1'b1;
        end
    end

    assign ramBus.ram_addr  = w_addr;
    assign ramBus.ram_wdata = COLOR;
    assign ramBus.ram_wren  = w_wren;
    assign pos_x   = r_posX;
    assign pos_y   = r_posY;
    assign dir     = r_dir;
    assign crashed = r_crashed;

endmodule

// File: tb/tb_tron_player.sv
// Directed bench for tron_player: stepping, turns, trail and border crashes, reset recovery.
module tb_tron_player;

    logic CLOCK_50 = 1'b0;
    logic reset, resetB, enable, keyCw, keyCcw;
    logic preloadEn;
    logic [12:0] preloadAddr;
    int nChecks = 0;
    int nPass = 0;

    logic [6:0] posX0, posX1, posX2, posX3;
    logic [5:0] posY0, posY1, posY2, posY3;
    logic [1:0] dir0, dir1, dir2, dir3;
    logic crashed0, crashed1, crashed2, crashed3;
    int wrCnt0 = 0;
    int wrCnt1 = 0;
    int wrCnt2 = 0;
    int wrCnt3 = 0;

    logic [7:0] mem [0:8191] = '{default: 8'h00};
    logic [7:0] rdPipe1 = 8'h00;
    logic [7:0] rdPipe2 = 8'h00;

    tron_player_if bus0 ();
    tron_player_if bus1 ();
    tron_player_if bus2 ();
    tron_player_if bus3 ();

    always #10 CLOCK_50 = ~CLOCK_50;

    tron_player #(.TICK_CYCLES(8)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
        .key_ccw_n(keyCcw), .key_cw_n(keyCw), .ramBus(bus0),
        .pos_x(posX0), .pos_y(posY0), .dir(dir0), .crashed(crashed0));

    tron_player #(.TICK_CYCLES(8), .INIT_X(77)) dutRight (
        .CLOCK_50(CLOCK_50), .reset(resetB), .enable(1'b1),
        .key_ccw_n(1'b1), .key_cw_n(1'b1), .ramBus(bus1),
        .pos_x(posX1), .pos_y(posY1), .dir(dir1), .crashed(crashed1));

    tron_player #(.TICK_CYCLES(8), .INIT_X(2), .INIT_DIR(2)) dutLeft (
        .CLOCK_50(CLOCK_50), .reset(resetB), .enable(1'b1),
        .key_ccw_n(1'b1), .key_cw_n(1'b1), .ramBus(bus2),
        .pos_x(posX2), .pos_y(posY2), .dir(dir2), .crashed(crashed2));

    tron_player #(.TICK_CYCLES(8), .BORDER(0), .INIT_X(0), .INIT_DIR(2)) dutWrap (
        .CLOCK_50(CLOCK_50), .reset(resetB), .enable(1'b1),
        .key_ccw_n(1'b1), .key_cw_n(1'b1), .ramBus(bus3),
        .pos_x(posX3), .pos_y(posY3), .dir(dir3), .crashed(crashed3));

    // Two-stage read pipe gives the main player a RAM with two cycles of read latency.
    always @(posedge CLOCK_50) begin
        rdPipe1 <= mem[bus0.ram_addr];
        rdPipe2 <= rdPipe1;
        if (bus0.ram_wren) begin
            mem[bus0.ram_addr] <= bus0.ram_wdata;
            wrCnt0 <= wrCnt0 + 1;
        end
        if (preloadEn) mem[preloadAddr] <= 8'h80;
        if (bus1.ram_wren) wrCnt1 <= wrCnt1 + 1;
        if (bus2.ram_wren) wrCnt2 <= wrCnt2 + 1;
        if (bus3.ram_wren) wrCnt3 <= wrCnt3 + 1;
    end

    assign bus0.ram_rdata = rdPipe2;
    assign bus1.ram_rdata = 8'h00;
    assign bus2.ram_rdata = 8'h00;
    assign bus3.ram_rdata = 8'h00;

    task automatic waitEdges(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) nPass++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Pulse the selected keys low for two cycles, then release for two; consumes four edges.
    task automatic applyStimulus(input logic cw, input logic ccw);
        keyCw  = ~cw;
        keyCcw = ~ccw;
        waitEdges(2);
        keyCw  = 1'b1;
        keyCcw = 1'b1;
        waitEdges(2);
    endtask

    // Called from the first IDLE cycle minus 'pre' edges already spent; WRITE lands 12 edges in.
    task automatic doStep(input string tag, input int pre, input int expAddr,
                          input int expX, input int expY, input int expDir);
        waitEdges(12 - pre);
        checkOutput({tag, "_wren"}, 32'(bus0.ram_wren), 1);
        checkOutput({tag, "_addr"}, 32'(bus0.ram_addr), 32'(expAddr));
        waitEdges(1);
        checkOutput({tag, "_x"}, 32'(posX0), 32'(expX));
        checkOutput({tag, "_y"}, 32'(posY0), 32'(expY));
        checkOutput({tag, "_dir"}, 32'(dir0), 32'(expDir));
        checkOutput({tag, "_crashed"}, 32'(crashed0), 0);
    endtask

    initial begin
        reset = 1'b1; resetB = 1'b1; enable = 1'b1;
        keyCw = 1'b1; keyCcw = 1'b1;
        preloadEn = 1'b0; preloadAddr = 13'd0;

        waitEdges(1);
        checkOutput("rst_x", 32'(posX0), 27);
        checkOutput("rst_y", 32'(posY0), 30);
        checkOutput("rst_dir", 32'(dir0), 0);
        checkOutput("rst_crashed", 32'(crashed0), 0);
        checkOutput("rst_wren", 32'(bus0.ram_wren), 0);
        reset = 1'b0; resetB = 1'b0;
        #1;
        checkOutput("init_wren", 32'(bus0.ram_wren), 1);
        checkOutput("init_addr", 32'(bus0.ram_addr), 2427);
        checkOutput("init_wdata", 32'(bus0.ram_wdata), 32'h0000_00FF);
        waitEdges(1);
        checkOutput("init_count", 32'(wrCnt0), 1);
        checkOutput("idle_wren", 32'(bus0.ram_wren), 0);
        checkOutput("idle_addr", 32'(bus0.ram_addr), 2427);

        doStep("step1", 0, 2428, 28, 30, 0);

        checkOutput("right_crashed", 32'(crashed1), 1);
        checkOutput("right_x", 32'(posX1), 77);
        checkOutput("right_writes", 32'(wrCnt1), 1);
        checkOutput("left_crashed", 32'(crashed2), 1);
        checkOutput("left_x", 32'(posX2), 2);
        checkOutput("wrap_crashed", 32'(crashed3), 1);
        checkOutput("wrap_x", 32'(posX3), 0);

        // Dropping enable during READ must still complete the step, then freeze the tick.
        waitEdges(9);
        enable = 1'b0;
        waitEdges(3);
        checkOutput("step2_wren", 32'(bus0.ram_wren), 1);
        checkOutput("step2_addr", 32'(bus0.ram_addr), 2429);
        waitEdges(1);
        checkOutput("step2_x", 32'(posX0), 29);
        waitEdges(12);
        checkOutput("frozen_x", 32'(posX0), 29);
        checkOutput("frozen_wren", 32'(bus0.ram_wren), 0);
        checkOutput("frozen_addr", 32'(bus0.ram_addr), 2429);
        enable = 1'b1;

        applyStimulus(1'b1, 1'b0);
        doStep("cw", 4, 2509, 29, 31, 1);
        applyStimulus(1'b1, 1'b1);
        doStep("both", 4, 2589, 29, 32, 1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        doStep("twoCw", 8, 2588, 28, 32, 2);
        applyStimulus(1'b0, 1'b1);
        doStep("ccw", 4, 2668, 28, 33, 1);

        preloadAddr = 13'd2748;
        preloadEn = 1'b1;
        waitEdges(1);
        preloadEn = 1'b0;
        waitEdges(12);
        checkOutput("trail_crashed", 32'(crashed0), 1);
        checkOutput("trail_x", 32'(posX0), 28);
        checkOutput("trail_y", 32'(posY0), 33);
        checkOutput("trail_wren", 32'(bus0.ram_wren), 0);
        checkOutput("trail_writes", 32'(wrCnt0), 7);
        waitEdges(10);
        checkOutput("crash_hold_writes", 32'(wrCnt0), 7);
        checkOutput("crash_hold_y", 32'(posY0), 33);

        reset = 1'b1;
        waitEdges(1);
        checkOutput("rstCrash_x", 32'(posX0), 27);
        checkOutput("rstCrash_dir", 32'(dir0), 0);
        checkOutput("rstCrash_crashed", 32'(crashed0), 0);
        checkOutput("rstCrash_wren", 32'(bus0.ram_wren), 0);
        reset = 1'b0;
        #1;
        checkOutput("rstCrash_initWren", 32'(bus0.ram_wren), 1);
        waitEdges(1);
        checkOutput("rstCrash_writes", 32'(wrCnt0), 8);

        waitEdges(9);
        checkOutput("read_addr", 32'(bus0.ram_addr), 2428);
        reset = 1'b1;
        waitEdges(1);
        checkOutput("rstRead_x", 32'(posX0), 27);
        checkOutput("rstRead_y", 32'(posY0), 30);
        checkOutput("rstRead_crashed", 32'(crashed0), 0);
        checkOutput("rstRead_addr", 32'(bus0.ram_addr), 2427);
        reset = 1'b0;
        #1;
        checkOutput("rstRead_initWren", 32'(bus0.ram_wren), 1);
        waitEdges(1);
        checkOutput("rstRead_writes", 32'(wrCnt0), 9);

        // Cell 2428 still holds the old trail, so the first step after restart crashes in EVAL.
        waitEdges(13);
        checkOutput("oldTrail_crashed", 32'(crashed0), 1);
        checkOutput("oldTrail_x", 32'(posX0), 27);
        checkOutput("oldTrail_writes", 32'(wrCnt0), 9);

        checkOutput("right_final_writes", 32'(wrCnt1), 1);
        checkOutput("left_final_writes", 32'(wrCnt2), 1);
        checkOutput("wrap_final_writes", 32'(wrCnt3), 1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
